// File: rtl/key_event_io.sv
// Push-button peripheral: synchronises and debounces active-low keys, latches
// press events (write-1-to-clear) and exposes LEVEL/EVENT registers plus an irq.
module key_event_io #(
   parameter int N_KEYS     = 4,
   parameter int DEB_CYCLES = 3,
   parameter int CNT_W      = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_KEYS-1:0] key_n,
   input  logic              sel,
   input  logic              reg_sel,
   input  logic              we,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              irq
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [N_KEYS-1:0] sync1_q;
   logic [N_KEYS-1:0] sync2_q;
   logic [N_KEYS-1:0] stable_q, stable_d;
   logic [CNT_W-1:0]  cnt_q [N_KEYS];
   logic [CNT_W-1:0]  cnt_d [N_KEYS];
   logic [N_KEYS-1:0] event_q, event_d;
   logic              irq_q;
   logic              clr_req;
   logic [N_KEYS-1:0] clr_mask;
   logic [N_KEYS-1:0] press;
   logic              unused_wdata_hi;

   // Upper write-data bits have no keys behind them.
   assign unused_wdata_hi = ^wdata;

   // Two-flop synchroniser; inversion makes 1 mean "pressed".
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= ~key_n;
         sync2_q <= sync1_q;
      end
   end

   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < N_KEYS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            stable_d[i] = sync2_q[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // A new press outranks a simultaneous clear so no press is ever lost.
   assign clr_req  = sel & we & reg_sel;
   assign clr_mask = wdata[N_KEYS-1:0] & {N_KEYS{clr_req}};
   assign press    = stable_d & ~stable_q;
   assign event_d  = (event_q & ~clr_mask) | press;

   always_ff @(posedge clk) begin
      if (reset) begin
         stable_q <= '0;
         cnt_q    <= '{default: '0};
         event_q  <= '0;
         irq_q    <= 1'b0;
      end else begin
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         event_q  <= event_d;
         irq_q    <= |event_q;
      end
   end

   always_comb begin
      rdata = '0;
      if (sel) begin
         if (reg_sel) begin
            rdata = 32'(event_q);
         end else begin
            rdata = 32'(stable_q);
         end
      end
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_key_event_io.sv
// Bench for key_event_io: directed vector table, hand sequences for bounce,
// set/clear collision and reset mid-debounce, then random traffic vs a model.
module tb_key_event_io;

   localparam int NK  = 4;
   localparam int DEB = 3;

   logic          clk;
   logic          reset;
   logic [NK-1:0] key_n;
   logic          sel;
   logic          reg_sel;
   logic          we;
   logic [31:0]   wdata;
   logic [31:0]   rdata;
   logic          irq;

   int n_checks = 0;
   int n_fail   = 0;

   key_event_io #(.N_KEYS(NK), .DEB_CYCLES(DEB), .CNT_W(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .key_n   (key_n),
      .sel     (sel),
      .reg_sel (reg_sel),
      .we      (we),
      .wdata   (wdata),
      .rdata   (rdata),
      .irq     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a key's level flips once the last DEB synchronised
   // samples all disagree with it; samples reach the debouncer two edges late.
   logic [NK-1:0] m_hist [0:DEB];
   logic [NK-1:0] m_level;
   logic [NK-1:0] m_event;
   logic          m_irq;

   task automatic model_step();
      logic [NK-1:0] nl;
      logic [NK-1:0] clr;
      if (reset) begin
         for (int j = 0; j <= DEB; j++) m_hist[j] = '0;
         m_level = '0;
         m_event = '0;
         m_irq   = 1'b0;
      end else begin
         nl = m_level;
         for (int k = 0; k < NK; k++) begin
            bit all_diff = 1'b1;
            for (int j = 1; j <= DEB; j++)
               if (m_hist[j][k] == m_level[k]) all_diff = 1'b0;
            if (all_diff) nl[k] = ~m_level[k];
         end
         clr     = (sel && we && reg_sel) ? wdata[NK-1:0] : '0;
         m_irq   = |m_event;
         m_event = (m_event & ~clr) | (nl & ~m_level);
         m_level = nl;
         for (int j = DEB; j >= 1; j--) m_hist[j] = m_hist[j-1];
         m_hist[0] = ~key_n;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reads all views of rdata between edges, then restores the stimulus.
   task automatic peek(output logic [31:0] lv, output logic [31:0] ev, output logic [31:0] nz);
      logic s_sel, s_rs;
      s_sel = sel; s_rs = reg_sel;
      sel = 1'b0; reg_sel = 1'b1; #1 nz = rdata;
      sel = 1'b1; reg_sel = 1'b0; #1 lv = rdata;
      reg_sel = 1'b1;             #1 ev = rdata;
      sel = s_sel; reg_sel = s_rs;
      #1;
   endtask

   task automatic expect_state(input string tag, input logic [31:0] el, input logic [31:0] ee, input logic ei);
      logic [31:0] lv, ev, nz;
      peek(lv, ev, nz);
      chk({tag, " level"}, lv, el);
      chk({tag, " event"}, ev, ee);
      chk({tag, " irq"}, {31'b0, irq}, {31'b0, ei});
      chk({tag, " unsel"}, nz, 32'h0);
   endtask

   task automatic drive(input logic r, input logic [NK-1:0] k, input logic s, input logic rs,
                        input logic w, input logic [31:0] d);
      reset = r; key_n = k; sel = s; reg_sel = rs; we = w; wdata = d;
   endtask

   typedef struct {
      logic          rst;
      logic [NK-1:0] key;
      logic          sel;
      logic          rs;
      logic          we;
      logic [31:0]   wd;
      int            cyc;
      logic [31:0]   lvl;
      logic [31:0]   evt;
      logic          irq;
   } vec_t;

   function automatic vec_t mk(logic r, logic [NK-1:0] k, logic s, logic rs, logic w,
                               logic [31:0] d, int c, logic [31:0] l, logic [31:0] e, logic i);
      vec_t v;
      v.rst = r; v.key = k; v.sel = s; v.rs = rs; v.we = w; v.wd = d;
      v.cyc = c; v.lvl = l; v.evt = e; v.irq = i;
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      logic [31:0] lv, ev, nz;
      drive(1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
      for (int j = 0; j <= DEB; j++) m_hist[j] = '0;
      m_level = '0; m_event = '0; m_irq = 1'b0;

      //            rst key   sel rs we wdata         cyc lvl evt irq
      tbl.push_back(mk(1, 4'hF, 0, 0, 0, 32'h0,        2, 0, 0, 0));
      tbl.push_back(mk(0, 4'hF, 0, 0, 0, 32'h0,        3, 0, 0, 0));
      tbl.push_back(mk(0, 4'hD, 0, 0, 0, 32'h0,        4, 0, 0, 0));
      tbl.push_back(mk(0, 4'hD, 0, 0, 0, 32'h0,        1, 2, 2, 0));
      tbl.push_back(mk(0, 4'hD, 0, 0, 0, 32'h0,        1, 2, 2, 1));
      tbl.push_back(mk(0, 4'h9, 0, 0, 0, 32'h0,        2, 2, 2, 1));
      tbl.push_back(mk(0, 4'hD, 0, 0, 0, 32'h0,        6, 2, 2, 1));
      tbl.push_back(mk(0, 4'h9, 0, 0, 0, 32'h0,        5, 6, 6, 1));
      tbl.push_back(mk(0, 4'h9, 1, 1, 1, 32'h4,        1, 6, 2, 1));
      tbl.push_back(mk(0, 4'h9, 0, 0, 0, 32'h0,        1, 6, 2, 1));
      tbl.push_back(mk(0, 4'h9, 1, 1, 1, 32'h2,        1, 6, 0, 1));
      tbl.push_back(mk(0, 4'h9, 0, 0, 0, 32'h0,        1, 6, 0, 0));
      tbl.push_back(mk(0, 4'hF, 0, 0, 0, 32'h0,        4, 6, 0, 0));
      tbl.push_back(mk(0, 4'hF, 0, 0, 0, 32'h0,        1, 0, 0, 0));
      tbl.push_back(mk(0, 4'hE, 0, 0, 0, 32'h0,        5, 1, 1, 0));
      tbl.push_back(mk(0, 4'hE, 0, 0, 0, 32'h0,        1, 1, 1, 1));
      tbl.push_back(mk(0, 4'hE, 1, 0, 1, 32'hFFFFFFFF, 1, 1, 1, 1));
      tbl.push_back(mk(0, 4'hE, 0, 1, 1, 32'hFFFFFFFF, 1, 1, 1, 1));
      tbl.push_back(mk(0, 4'hE, 1, 1, 1, 32'hFFFFFFF0, 1, 1, 1, 1));
      tbl.push_back(mk(0, 4'hE, 1, 1, 1, 32'h1,        1, 1, 0, 1));
      tbl.push_back(mk(0, 4'hE, 0, 0, 0, 32'h0,        1, 1, 0, 0));

      @(negedge clk);
      for (int n = 0; n < tbl.size(); n++) begin
         drive(tbl[n].rst, tbl[n].key, tbl[n].sel, tbl[n].rs, tbl[n].we, tbl[n].wd);
         repeat (tbl[n].cyc) tick();
         expect_state($sformatf("vec%0d", n), tbl[n].lvl, tbl[n].evt, tbl[n].irq);
      end

      // Bounce on key0: the counter must restart, so only the final low run counts.
      drive(0, 4'hF, 0, 0, 0, 32'h0); repeat (6) tick();
      expect_state("bounce idle", 0, 0, 0);
      drive(0, 4'hE, 0, 0, 0, 32'h0); repeat (2) tick();
      drive(0, 4'hF, 0, 0, 0, 32'h0); repeat (1) tick();
      drive(0, 4'hE, 0, 0, 0, 32'h0); repeat (4) tick();
      expect_state("bounce early", 0, 0, 0);
      tick();
      expect_state("bounce accept", 1, 1, 0);

      // Clear colliding with a new press of the same key: the press wins.
      drive(0, 4'hE, 1, 1, 1, 32'hF); tick();
      drive(0, 4'hD, 0, 0, 0, 32'h0); repeat (6) tick();
      expect_state("coll press1", 2, 2, 1);
      drive(0, 4'hF, 0, 0, 0, 32'h0); repeat (6) tick();
      expect_state("coll release", 0, 2, 1);
      drive(0, 4'hD, 0, 0, 0, 32'h0); repeat (4) tick();
      expect_state("coll pre", 0, 2, 1);
      drive(0, 4'hD, 1, 1, 1, 32'h2); tick();
      expect_state("coll setwins", 2, 2, 1);
      drive(0, 4'hD, 1, 1, 1, 32'h2); tick();
      drive(0, 4'hD, 0, 0, 0, 32'h0); tick();
      expect_state("coll cleared", 2, 0, 0);

      // Reset while key3 is mid-debounce, key held through and after reset.
      drive(0, 4'h7, 0, 0, 0, 32'h0); repeat (3) tick();
      drive(1, 4'h7, 0, 0, 0, 32'h0); tick();
      expect_state("rst mid", 0, 0, 0);
      drive(0, 4'h7, 0, 0, 0, 32'h0); repeat (4) tick();
      expect_state("rst held early", 0, 0, 0);
      tick();
      expect_state("rst held accept", 8, 8, 0);
      tick();
      expect_state("rst held irq", 8, 8, 1);
      drive(1, 4'h7, 0, 0, 0, 32'h0); tick();
      expect_state("rst pending", 0, 0, 0);

      // Random traffic against the model.
      drive(0, 4'hF, 0, 0, 0, 32'h0);
      for (int c = 0; c < 3000; c++) begin
         logic [NK-1:0] k;
         k = key_n;
         for (int b = 0; b < NK; b++)
            if ($urandom_range(7) == 0) k[b] = ~k[b];
         if ($urandom_range(5) == 0)
            drive(($urandom_range(299) == 0), k, 1'($urandom_range(1)), 1'($urandom_range(1)),
                  1'b1, $urandom());
         else
            drive(($urandom_range(299) == 0), k, 1'($urandom_range(1)), 1'($urandom_range(1)),
                  1'b0, $urandom());
         tick();
         peek(lv, ev, nz);
         chk("rand level", lv, 32'(m_level));
         chk("rand event", ev, 32'(m_event));
         chk("rand irq", {31'b0, irq}, {31'b0, m_irq});
         chk("rand unsel", nz, 32'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
